// File: rtl/l2_mem_arbiter.sv
// rtl/l2_mem_arbiter.sv - I-cache / D-cache line-miss arbiter in front of a single L2 port
// One line transaction at a time; round-robin on ties unless D_PRIO forces D to win.
module l2_mem_arbiter #(
  parameter int AW     = 28,
  parameter int DW     = 128,
  parameter bit D_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_read,
  input  logic          i_write,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_read,
  input  logic          d_write,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          grant_d
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t state, state_nxt;
  logic   last_d, last_d_nxt;
  logic   req_i, req_d;
  logic   take_i, take_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b1;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    take_i     = 1'b0;
    take_d     = 1'b0;
    req_i      = i_read | i_write;
    req_d      = d_read | d_write;
    case (state)
      IDLE: begin
        if (req_i && req_d) begin
          // the round-robin pointer only moves when both sides compete
          if (D_PRIO || !last_d) take_d = 1'b1;
          else                   take_i = 1'b1;
          if (!D_PRIO) last_d_nxt = take_d;
        end else if (req_i) begin
          take_i = 1'b1;
        end else if (req_d) begin
          take_d = 1'b1;
        end
        if (take_d)      state_nxt = BUSY_D;
        else if (take_i) state_nxt = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      grant_d   <= 1'b0;
      i_rdata   <= '0;
      i_ready   <= 1'b0;
      d_rdata   <= '0;
      d_ready   <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      if (take_i || take_d) begin
        // a simultaneous read+write request is served as the write
        mem_addr  <= take_d ? d_addr  : i_addr;
        mem_wdata <= take_d ? d_wdata : i_wdata;
        mem_write <= take_d ? d_write : i_write;
        mem_read  <= take_d ? (d_read & ~d_write) : (i_read & ~i_write);
        grant_d   <= take_d;
      end
      if ((state == BUSY_I || state == BUSY_D) && mem_ready) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        grant_d   <= 1'b0;
        if (state == BUSY_D) begin
          d_rdata <= mem_rdata;
          d_ready <= 1'b1;
        end else begin
          i_rdata <= mem_rdata;
          i_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// tb/tb_l2_mem_arbiter.sv - randomized scoreboard bench for l2_mem_arbiter
// Transaction-level model predicts grants; monitors check memory ops and ready pulses.
module tb_l2_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam bit TB_D_PRIO = 1'b0;

  typedef struct {
    bit            side_d;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            cyc;
  } mem_exp_t;

  typedef struct {
    logic [DW-1:0] rdata;
    int            cyc;
  } rdy_exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata, i_rdata, d_rdata;
  logic          i_ready, d_ready;
  logic          mem_read, mem_write, mem_ready, grant_d;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          p_i_read, p_d_read, p_i_ready, p_d_ready;
  logic [DW-1:0] p_i_rdata, p_d_rdata, p_mem_wdata, p_mem_rdata;
  logic [AW-1:0] p_mem_addr;
  logic          p_mem_read, p_mem_write, p_mem_ready, p_grant_d;

  int       n_cmp = 0;
  int       n_bad = 0;
  int       cyc;
  mem_exp_t mem_q[$];
  rdy_exp_t ri_q[$];
  rdy_exp_t rd_q[$];
  bit       mem_auto;
  int       spur_req;

  always #5 clk = ~clk;

  l2_mem_arbiter #(.AW(AW), .DW(DW), .D_PRIO(TB_D_PRIO)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant_d(grant_d)
  );

  l2_mem_arbiter #(.AW(AW), .DW(DW), .D_PRIO(1'b1)) dut_p (
    .clk(clk), .rst(rst),
    .i_read(p_i_read), .i_write(1'b0), .i_addr(28'h0000040), .i_wdata('0),
    .i_rdata(p_i_rdata), .i_ready(p_i_ready),
    .d_read(p_d_read), .d_write(1'b0), .d_addr(28'h1234567), .d_wdata('0),
    .d_rdata(p_d_rdata), .d_ready(p_d_ready),
    .mem_read(p_mem_read), .mem_write(p_mem_write), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
    .mem_rdata(p_mem_rdata), .mem_ready(p_mem_ready), .grant_d(p_grant_d)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    return r[AW-1:0];
  endfunction

  // reference model: a grant is due on the first free edge that sees a request
  initial begin
    bit       ri, rq_d, pick_d, m_busy, m_last_d;
    int       m_free_from;
    mem_exp_t e;
    cyc = 0; m_busy = 0; m_free_from = 0; m_last_d = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_busy = 0; m_last_d = 1'b1; m_free_from = cyc + 1;
      end else if (m_busy) begin
        if (mem_ready) begin m_busy = 0; m_free_from = cyc + 2; end
      end else if (cyc >= m_free_from) begin
        ri   = i_read | i_write;
        rq_d = d_read | d_write;
        if (ri || rq_d) begin
          if (ri && rq_d) begin
            pick_d = TB_D_PRIO ? 1'b1 : !m_last_d;
            m_last_d = pick_d;
          end else begin
            pick_d = rq_d;
          end
          e.side_d = pick_d;
          e.wr     = pick_d ? d_write : i_write;
          e.addr   = pick_d ? d_addr  : i_addr;
          e.wdata  = pick_d ? d_wdata : i_wdata;
          e.cyc    = cyc;
          mem_q.push_back(e);
          m_busy = 1;
        end
      end
    end
  end

  // downstream memory: checks each issued op, then answers after a random delay
  initial begin
    mem_exp_t      e;
    rdy_exp_t      r;
    bit            sd;
    logic [1:0]    op0;
    logic [AW-1:0] a0;
    int            spur_done, k;
    mem_ready = 1'b0; mem_rdata = '0; spur_done = 0;
    forever begin
      @(negedge clk);
      if (!rst && (mem_read || mem_write)) begin
        op0 = {mem_read, mem_write};
        a0  = mem_addr;
        if (mem_q.size() == 0) begin
          chk("mem_op_unexpected", 128'(mem_read | mem_write), '0);
          sd = grant_d;
        end else begin
          e  = mem_q.pop_front();
          sd = e.side_d;
          chk("mem_grant_d", 128'(grant_d), 128'(e.side_d));
          chk("mem_op", 128'({mem_read, mem_write}), 128'({!e.wr, e.wr}));
          chk("mem_addr", 128'(mem_addr), 128'(e.addr));
          chk("mem_wdata", mem_wdata, e.wdata);
          chk("mem_issue_cycle", 128'(cyc), 128'(e.cyc));
        end
        if (mem_auto) begin
          repeat ($urandom_range(0, 5)) @(posedge clk);
          @(posedge clk); #1;
          chk("mem_held", 128'({mem_read, mem_write, mem_addr}), 128'({op0, a0}));
          mem_ready = 1'b1;
          mem_rdata = rand_line();
          r.rdata = mem_rdata;
          r.cyc   = cyc + 1;
          if (sd) rd_q.push_back(r);
          else    ri_q.push_back(r);
          @(posedge clk); #1;
          mem_ready = 1'b0;
        end else begin
          k = 0;
          while ((mem_read || mem_write) && k < 1000) begin @(negedge clk); k++; end
        end
      end else if (spur_req != spur_done) begin
        @(posedge clk); #1;
        mem_ready = 1'b1; mem_rdata = rand_line();
        @(posedge clk); #1;
        mem_ready = 1'b0;
        spur_done++;
      end
    end
  end

  // ready monitor: every pulse must match a completion the memory produced
  initial begin
    rdy_exp_t      r;
    logic [DW-1:0] hold_i, hold_d;
    hold_i = '0; hold_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_i = '0; hold_d = '0;
      end else begin
        if (i_ready) begin
          if (ri_q.size() == 0) begin
            chk("i_ready_unexpected", 128'(i_ready), '0);
          end else begin
            r = ri_q.pop_front();
            chk("i_rdata", i_rdata, r.rdata);
            chk("i_ready_cycle", 128'(cyc), 128'(r.cyc));
          end
          hold_i = i_rdata;
        end else begin
          chk("i_rdata_hold", i_rdata, hold_i);
        end
        if (d_ready) begin
          if (rd_q.size() == 0) begin
            chk("d_ready_unexpected", 128'(d_ready), '0);
          end else begin
            r = rd_q.pop_front();
            chk("d_rdata", d_rdata, r.rdata);
            chk("d_ready_cycle", 128'(cyc), 128'(r.cyc));
          end
          hold_d = d_rdata;
        end else begin
          chk("d_rdata_hold", d_rdata, hold_d);
        end
      end
    end
  end

  // fixed-latency memory for the D-priority instance
  initial begin
    p_mem_ready = 1'b0; p_mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && (p_mem_read || p_mem_write)) begin
        @(posedge clk); #1;
        p_mem_ready = 1'b1; p_mem_rdata = rand_line();
        @(posedge clk); #1;
        p_mem_ready = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic drive_req(input bit side, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] w);
    if (side) begin d_read = rd; d_write = wr; d_addr = a; d_wdata = w; end
    else      begin i_read = rd; i_write = wr; i_addr = a; i_wdata = w; end
  endtask

  task automatic requester(input bit side, input int n);
    int            gap, op, k;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    for (int t = 0; t < n; t++) begin
      gap = (t == 0) ? 0 : int'($urandom_range(0, 3));
      if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
      op = int'($urandom_range(0, 3));
      a  = rand_addr();
      w  = rand_line();
      drive_req(side, op != 2, op >= 2, a, w);
      k = 0;
      do begin @(negedge clk); k++; end
      while (!(side ? d_ready : i_ready) && k < 300);
      chk(side ? "d_req_timeout" : "i_req_timeout", 128'(k < 300), 128'(1));
      @(posedge clk); #1;
      drive_req(side, 1'b0, 1'b0, a, w);
    end
  endtask

  task automatic p_test();
    bit p_order[$];
    int k;
    for (int rnd = 0; rnd < 2; rnd++) begin
      @(posedge clk); #1;
      p_i_read = 1'b1; p_d_read = 1'b1;
      k = 0;
      while ((p_i_read || p_d_read) && k < 100) begin
        @(negedge clk); k++;
        if (p_d_ready) begin p_order.push_back(1'b1); p_d_read = 1'b0; end
        if (p_i_ready) begin p_order.push_back(1'b0); p_i_read = 1'b0; end
      end
    end
    chk("prio_count", 128'(p_order.size()), 128'(4));
    for (int j = 0; j < p_order.size(); j++)
      chk("prio_order", 128'(p_order[j]), 128'(j % 2 == 0));
  endtask

  initial begin
    int k;
    rst = 1'b1; mem_auto = 1'b1; spur_req = 0;
    i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    p_i_read = 0; p_d_read = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 128'({mem_read, mem_write, grant_d, i_ready, d_ready,
                          p_mem_read, p_mem_write, p_grant_d, p_i_ready, p_d_ready}), '0);
    chk("rst_mem_bus", 128'({mem_addr, mem_wdata}), '0);
    chk("rst_rdata", i_rdata | d_rdata | p_i_rdata | p_d_rdata, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    fork
      requester(1'b0, 40);
      requester(1'b1, 40);
      p_test();
    join

    // spurious mem_ready while idle, then a combined read+write from D
    repeat (3) @(posedge clk);
    spur_req++;
    repeat (4) begin @(negedge clk); chk("spur_no_ready", 128'({i_ready, d_ready, mem_read, mem_write}), '0); end
    @(posedge clk); #1;
    drive_req(1'b1, 1'b1, 1'b1, rand_addr(), rand_line());
    k = 0;
    do begin @(negedge clk); k++; end while (!d_ready && k < 50);
    chk("rw_done", 128'(d_ready), 128'(1));
    @(posedge clk); #1;
    d_read = 0; d_write = 0;

    // reset while BUSY_D with no memory response
    repeat (3) @(posedge clk);
    mem_auto = 1'b0;
    #1;
    drive_req(1'b1, 1'b1, 1'b0, rand_addr(), rand_line());
    k = 0;
    do begin @(negedge clk); k++; end while (!mem_read && k < 20);
    chk("busy_issue", 128'({mem_read, grant_d}), 128'(2'b11));
    @(posedge clk); #1;
    rst = 1'b1; d_read = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", 128'({mem_read, mem_write, grant_d, i_ready, d_ready}), '0);
    chk("midrst_bus", 128'({mem_addr, mem_wdata}), '0);
    chk("midrst_rdata", i_rdata | d_rdata, '0);
    spur_req++;
    repeat (5) begin @(negedge clk); chk("midrst_no_ready", 128'({i_ready, d_ready, mem_read}), '0); end
    mem_auto = 1'b1;

    repeat (5) @(posedge clk);
    chk("mem_q_left", 128'(mem_q.size()), '0);
    chk("i_q_left", 128'(ri_q.size()), '0);
    chk("d_q_left", 128'(rd_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
